// File: rtl/turn_pkg.sv
// ============================================================================
//  Module      : turn_pkg
//  Description : Shared types and lamp-pattern constants for the turn-signal
//                sequencer/decoder pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package turn_pkg;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_L1  = 3'b001;
  localparam logic [2:0] PAT_L2  = 3'b011;
  localparam logic [2:0] PAT_L3  = 3'b111;
  localparam logic [2:0] PAT_R1  = 3'b100;
  localparam logic [2:0] PAT_R2  = 3'b110;
  localparam logic [2:0] PAT_R3  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_L0   = 4'd1,
    ST_L1   = 4'd2,
    ST_L2   = 4'd3,
    ST_L3   = 4'd4,
    ST_R0   = 4'd5,
    ST_R1   = 4'd6,
    ST_R2   = 4'd7,
    ST_R3   = 4'd8
  } turn_state_e;

  typedef enum logic [2:0] {
    PC_OFF     = 3'd0,
    PC_L1      = 3'd1,
    PC_L2      = 3'd2,
    PC_L3      = 3'd3,
    PC_R1      = 3'd4,
    PC_R2      = 3'd5,
    PC_R3      = 3'd6,
    PC_ILLEGAL = 3'd7
  } pat_class_e;

  function automatic logic is_left(input turn_state_e s);
    return (s == ST_L0) || (s == ST_L1) || (s == ST_L2) || (s == ST_L3);
  endfunction

  function automatic logic is_right(input turn_state_e s);
    return (s == ST_R0) || (s == ST_R1) || (s == ST_R2) || (s == ST_R3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/turn_pat_classify.sv
// ============================================================================
//  Module      : turn_pat_classify
//  Description : Combinational classifier of a (left, right) lamp pattern pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_pat_classify
  import turn_pkg::*;
(
  input  logic [2:0] l_lamp,
  input  logic [2:0] r_lamp,
  output pat_class_e pat_class
);

  // PAT_L3 and PAT_R3 share an encoding; which side is dark disambiguates.
  always_comb begin
    pat_class = PC_ILLEGAL;
    if (r_lamp == PAT_OFF) begin
      case (l_lamp)
        PAT_OFF: pat_class = PC_OFF;
        PAT_L1:  pat_class = PC_L1;
        PAT_L2:  pat_class = PC_L2;
        PAT_L3:  pat_class = PC_L3;
        default: pat_class = PC_ILLEGAL;
      endcase
    end else if (l_lamp == PAT_OFF) begin
      case (r_lamp)
        PAT_R1:  pat_class = PC_R1;
        PAT_R2:  pat_class = PC_R2;
        PAT_R3:  pat_class = PC_R3;
        default: pat_class = PC_ILLEGAL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/turn_decoder.sv
// ============================================================================
//  Module      : turn_decoder
//  Description : Tracks left/right lamp sweeps, counts completed sweeps and
//                flags illegal patterns. TURN_DEC_ERR_CNT_EN adds err_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_decoder
  import turn_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [2:0]       l_lamp,
  input  logic [2:0]       r_lamp,
  input  logic             err_clr,
  output logic             left_active,
  output logic             right_active,
  output logic [CNT_W-1:0] sweep_count,
  output logic             seq_error
`ifdef TURN_DEC_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  turn_state_e      r_state;
  turn_state_e      w_state_nxt;
  pat_class_e       w_class;
  logic [2:0]       r_prev_l;
  logic [2:0]       r_prev_r;
  logic             w_held;
  logic             w_err;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] r_sweep_cnt;
  logic             r_seq_err;

  turn_pat_classify u_classify (
    .l_lamp    (l_lamp),
    .r_lamp    (r_lamp),
    .pat_class (w_class)
  );

  assign w_held = (l_lamp == r_prev_l) && (r_lamp == r_prev_r) &&
                  ((l_lamp | r_lamp) != PAT_OFF);

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_cnt_inc   = 1'b0;
    case (w_class)
      PC_OFF: begin
        if (r_state == ST_L3) begin
          w_state_nxt = ST_L0;
          w_cnt_inc   = 1'b1;
        end else if (r_state == ST_R3) begin
          w_state_nxt = ST_R0;
          w_cnt_inc   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      PC_L1: begin
        if (r_state == ST_IDLE || r_state == ST_L0 || is_right(r_state))
          w_state_nxt = ST_L1;
        else
          w_err = 1'b1;
      end
      PC_L2: if (r_state == ST_L1) w_state_nxt = ST_L2; else w_err = 1'b1;
      PC_L3: if (r_state == ST_L2) w_state_nxt = ST_L3; else w_err = 1'b1;
      PC_R1: begin
        if (r_state == ST_IDLE || r_state == ST_R0 || is_left(r_state))
          w_state_nxt = ST_R1;
        else
          w_err = 1'b1;
      end
      PC_R2: if (r_state == ST_R1) w_state_nxt = ST_R2; else w_err = 1'b1;
      PC_R3: if (r_state == ST_R2) w_state_nxt = ST_R3; else w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
    // A repeated pattern is an error even where the table alone would accept it.
    if (w_held)
      w_err = 1'b1;
    if (w_err) begin
      w_state_nxt = ST_IDLE;
      w_cnt_inc   = 1'b0;
    end
    if (!sample_en) begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_prev_l    <= PAT_OFF;
      r_prev_r    <= PAT_OFF;
      r_sweep_cnt <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (sample_en) begin
        r_prev_l <= l_lamp;
        r_prev_r <= r_lamp;
      end
      if (w_cnt_inc)
        r_sweep_cnt <= r_sweep_cnt + C_CNT_ONE;
      if (w_err)
        r_seq_err <= 1'b1;
      else if (err_clr)
        r_seq_err <= 1'b0;
    end
  end

  assign left_active  = is_left(r_state);
  assign right_active = is_right(r_state);
  assign sweep_count  = r_sweep_cnt;
  assign seq_error    = r_seq_err;

`ifdef TURN_DEC_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_err_cnt <= 8'd0;
    else if (w_err && err_clr)
      r_err_cnt <= 8'd1;
    else if (err_clr)
      r_err_cnt <= 8'd0;
    else if (w_err && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_count = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_turn_decoder.sv
// ============================================================================
//  Module      : tb_turn_decoder
//  Description : Directed self-checking bench for turn_decoder with a
//                sweep-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_decoder;

  localparam int CNT_W = 2;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             sample_en = 1'b0;
  logic             err_clr   = 1'b0;
  logic [2:0]       l_lamp    = 3'b000;
  logic [2:0]       r_lamp    = 3'b000;
  logic             left_active;
  logic             right_active;
  logic             seq_error;
  logic [CNT_W-1:0] sweep_count;
`ifdef TURN_DEC_ERR_CNT_EN
  logic [7:0]       err_count;
`endif

  always #5 clock = ~clock;

  turn_decoder #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_en    (sample_en),
    .l_lamp       (l_lamp),
    .r_lamp       (r_lamp),
    .err_clr      (err_clr),
    .left_active  (left_active),
    .right_active (right_active),
    .sweep_count  (sweep_count),
    .seq_error    (seq_error)
`ifdef TURN_DEC_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // Reference model: direction (0 none, 1 left, 2 right) and step within sweep.
  logic [2:0] LSEQ [3];
  logic [2:0] RSEQ [3];
  int         m_dir, m_step, m_cnt, m_ecnt;
  bit         m_err;
  logic [2:0] m_pl, m_pr;
  bit         check_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  initial begin
    LSEQ[0] = 3'b001; LSEQ[1] = 3'b011; LSEQ[2] = 3'b111;
    RSEQ[0] = 3'b100; RSEQ[1] = 3'b110; RSEQ[2] = 3'b111;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_step = 0; m_cnt = 0; m_ecnt = 0; m_err = 1'b0;
    m_pl = 3'b000; m_pr = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] l, input logic [2:0] r,
                            input bit en, input bit clr);
    bit e;
    bit legal;
    bit ok;
    e = 1'b0;
    if (en) begin
      if ((l | r) != 3'b000 && l == m_pl && r == m_pr) begin
        e = 1'b1;
      end else if (l == 3'b000 && r == 3'b000) begin
        if (m_dir != 0 && m_step == 3) begin
          m_step = 0;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end else begin
          m_dir = 0;
        end
      end else begin
        legal = 1'b0;
        for (int k = 0; k < 3; k++) begin
          for (int d = 1; d <= 2; d++) begin
            if ((d == 1 && r == 3'b000 && l == LSEQ[k]) ||
                (d == 2 && l == 3'b000 && r == RSEQ[k])) begin
              ok = (k == 0) ? (m_dir != d || m_step == 0)
                            : (m_dir == d && m_step == k);
              if (ok) begin
                m_dir = d;
                m_step = k + 1;
                legal = 1'b1;
              end
            end
          end
        end
        if (!legal) e = 1'b1;
      end
      if (e) m_dir = 0;
      m_pl = l;
      m_pr = r;
    end
    if (e) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (e && clr) m_ecnt = 1;
    else if (clr) m_ecnt = 0;
    else if (e && m_ecnt < 255) m_ecnt++;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (check_en) begin
      chk("left_active",  left_active,  (m_dir == 1) ? 1 : 0);
      chk("right_active", right_active, (m_dir == 2) ? 1 : 0);
      chk("sweep_count",  sweep_count,  m_cnt);
      chk("seq_error",    seq_error,    m_err);
`ifdef TURN_DEC_ERR_CNT_EN
      chk("err_count",    err_count,    m_ecnt);
`endif
    end
  end

  task automatic cyc(input logic [2:0] l, input logic [2:0] r,
                     input bit en = 1'b1, input bit clr = 1'b0);
    @(negedge clock);
    #1;
    l_lamp = l; r_lamp = r; sample_en = en; err_clr = clr;
    @(posedge clock);
    model_step(l, r, en, clr);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    l_lamp = 3'b000; r_lamp = 3'b000; sample_en = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic left_sweep();
    cyc(3'b001, 3'b000); cyc(3'b011, 3'b000); cyc(3'b111, 3'b000); cyc(3'b000, 3'b000);
  endtask

  task automatic right_sweep();
    cyc(3'b000, 3'b100); cyc(3'b000, 3'b110); cyc(3'b000, 3'b111); cyc(3'b000, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    check_en = 1'b1;
    #1;
    chk("reset_left",  left_active,  0);
    chk("reset_sweep", sweep_count,  0);
    chk("reset_err",   seq_error,    0);
    do_reset();

    // Single left sweep
    cyc(3'b000, 3'b000);
    cyc(3'b001, 3'b000);
    chk("s1_left_after_001", left_active, 1);
    cyc(3'b011, 3'b000); cyc(3'b111, 3'b000); cyc(3'b000, 3'b000);
    chk("s1_sweep", sweep_count, 1);
    chk("s1_err",   seq_error,   0);

    // Two back-to-back right sweeps then release
    do_reset();
    right_sweep();
    right_sweep();
    chk("s2_sweep",   sweep_count,  2);
    chk("s2_right_r0", right_active, 1);
    cyc(3'b000, 3'b000);
    chk("s2_right_off", right_active, 0);

    // Left partial sweep handed over to right
    do_reset();
    cyc(3'b001, 3'b000); cyc(3'b011, 3'b000); cyc(3'b000, 3'b100);
    chk("s3_right", right_active, 1);
    chk("s3_left",  left_active,  0);
    chk("s3_err",   seq_error,    0);
    chk("s3_sweep", sweep_count,  0);

    // Skipped step, clear collision, clear alone
    do_reset();
    cyc(3'b001, 3'b000); cyc(3'b111, 3'b000);
    chk("s4_err",  seq_error,   1);
    chk("s4_idle", left_active, 0);
    cyc(3'b001, 3'b100, 1'b1, 1'b1);
    chk("s4_err_wins", seq_error, 1);
    cyc(3'b000, 3'b000, 1'b1, 1'b1);
    chk("s4_cleared", seq_error, 0);

    // Held pattern is an error; a gap of unsampled cycles is not
    do_reset();
    cyc(3'b001, 3'b000); cyc(3'b011, 3'b000); cyc(3'b011, 3'b000);
    chk("s5_held_err", seq_error, 1);
    do_reset();
    cyc(3'b001, 3'b000); cyc(3'b011, 3'b000); cyc(3'b011, 3'b000, 1'b0);
    cyc(3'b111, 3'b000);
    chk("s5_gap_noerr", seq_error,   0);
    chk("s5_gap_left",  left_active, 1);
    cyc(3'b000, 3'b000);
    chk("s5_gap_sweep", sweep_count, 1);

    // Same pattern re-presented after an error must still be flagged
    do_reset();
    cyc(3'b001, 3'b000); cyc(3'b001, 3'b000, 1'b1, 1'b1); cyc(3'b001, 3'b000, 1'b1, 1'b1);
    chk("s6_reheld_err", seq_error, 1);

    // Assorted illegal pairs and a paused mid-sweep
    do_reset();
    cyc(3'b101, 3'b000); cyc(3'b000, 3'b001); cyc(3'b010, 3'b010);
    cyc(3'b000, 3'b000, 1'b1, 1'b1);
    cyc(3'b000, 3'b100); cyc(3'b000, 3'b110, 1'b0); cyc(3'b000, 3'b110);
    cyc(3'b000, 3'b111); cyc(3'b000, 3'b000);
    chk("s7_sweep", sweep_count, 1);

    // Counter wrap with CNT_W=2, then async reset mid-sweep
    do_reset();
    repeat (5) left_sweep();
    chk("s8_wrap", sweep_count, 1);
    cyc(3'b001, 3'b000); cyc(3'b011, 3'b000);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("s8_async_left",  left_active,  0);
    chk("s8_async_sweep", sweep_count,  0);
    chk("s8_async_err",   seq_error,    0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;

`ifdef TURN_DEC_ERR_CNT_EN
    do_reset();
    repeat (300) cyc(3'b001, 3'b100);
    chk("s9_ecnt_sat", err_count, 255);
    cyc(3'b001, 3'b100, 1'b1, 1'b1);
    chk("s9_ecnt_one", err_count, 1);
    cyc(3'b000, 3'b000, 1'b1, 1'b1);
    chk("s9_ecnt_clr", err_count, 0);
`endif

    @(negedge clock);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
